// File: rtl/led_pwm_fader.sv
// Three-channel LED PWM driver with per-channel linear fade toward a commanded level.
// Commands are buffered one deep and land on frame boundaries; levels ramp one LSB per step.
module led_pwm_fader #(
  parameter int PWM_BITS    = 8,
  parameter int RAMP_FRAMES = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_chan,
  input  logic [PWM_BITS-1:0] cmd_level,
  output logic [2:0]          pwm,
  output logic [2:0]          busy,
  output logic                frame_tick,
  output logic                cmd_err
);

  localparam logic [PWM_BITS-1:0] CNT_LAST  = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [7:0]          RAMP_LAST = 8'(RAMP_FRAMES - 1);

  logic [PWM_BITS-1:0] cnt;
  logic [7:0]          ramp_cnt;
  logic [PWM_BITS-1:0] cur [3];
  logic [PWM_BITS-1:0] tgt [3];
  logic [PWM_BITS-1:0] cur_nxt [3];
  logic [PWM_BITS-1:0] tgt_nxt [3];
  logic                pend_vld;
  logic                pend_vld_nxt;
  logic [1:0]          pend_chan;
  logic [PWM_BITS-1:0] pend_level;
  logic                accept;
  logic                step;
  logic                apply;

  // Move one LSB toward the target; the strict compares make overshoot and wrap impossible.
  function automatic logic [PWM_BITS-1:0] step_toward(input logic [PWM_BITS-1:0] c,
                                                      input logic [PWM_BITS-1:0] t);
    if (c < t) return c + 1'b1;
    if (c > t) return c - 1'b1;
    return c;
  endfunction

  assign frame_tick = (cnt == CNT_LAST);

  always_comb begin
    accept = cmd_valid && cmd_ready;
    step   = frame_tick && (ramp_cnt == RAMP_LAST);
    apply  = frame_tick && pend_vld;
    pend_vld_nxt = pend_vld;
    if (accept && (cmd_chan != 2'd3)) pend_vld_nxt = 1'b1;
    else if (apply)                   pend_vld_nxt = 1'b0;
    // Step decisions use the pre-update target; a new target takes effect next step.
    for (int i = 0; i < 3; i++) begin
      tgt_nxt[i] = tgt[i];
      cur_nxt[i] = cur[i];
      if (apply && (pend_chan == 2'(i))) tgt_nxt[i] = pend_level;
      if (step) cur_nxt[i] = step_toward(cur[i], tgt[i]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt        <= '0;
      ramp_cnt   <= '0;
      pend_vld   <= 1'b0;
      pend_chan  <= '0;
      pend_level <= '0;
      cmd_ready  <= 1'b0;
      cmd_err    <= 1'b0;
      pwm        <= '0;
      busy       <= '0;
      for (int i = 0; i < 3; i++) begin
        cur[i] <= '0;
        tgt[i] <= '0;
      end
    end else begin
      cnt <= frame_tick ? '0 : cnt + 1'b1;
      if (frame_tick) ramp_cnt <= step ? 8'd0 : ramp_cnt + 8'd1;
      pend_vld  <= pend_vld_nxt;
      cmd_ready <= !pend_vld_nxt;
      cmd_err   <= accept && (cmd_chan == 2'd3);
      if (accept && (cmd_chan != 2'd3)) begin
        pend_chan  <= cmd_chan;
        pend_level <= cmd_level;
      end
      for (int i = 0; i < 3; i++) begin
        cur[i]  <= cur_nxt[i];
        tgt[i]  <= tgt_nxt[i];
        pwm[i]  <= (cur[i] > cnt);
        busy[i] <= (cur_nxt[i] != tgt_nxt[i]);
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader: 6-bit PWM (63-cycle frame), one frame per ramp step.
module tb_led_pwm_fader;
  localparam int PB    = 6;
  localparam int RF    = 1;
  localparam int FRAME = 63;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_chan = 2'd0;
  logic [PB-1:0] cmd_level = '0;
  logic          cmd_ready, frame_tick, cmd_err;
  logic [2:0]    pwm, busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int chan;
    int level;
    int exp_err;
    int exp0;
    int exp1;
    int exp2;
  } vec_t;
  vec_t tbl [5];

  always #5 clk = ~clk;

  led_pwm_fader #(.PWM_BITS(PB), .RAMP_FRAMES(RF)) dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_chan(cmd_chan), .cmd_level(cmd_level), .pwm(pwm), .busy(busy),
    .frame_tick(frame_tick), .cmd_err(cmd_err)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!cmd_ready && n < 3*FRAME) begin @(negedge clk); n++; end
    check({name, " ready wait"}, int'(cmd_ready), 1);
  endtask

  task automatic wait_tick(input string name);
    int n = 0;
    while (!frame_tick && n < 2*FRAME) begin @(negedge clk); n++; end
    check({name, " tick wait"}, int'(frame_tick), 1);
  endtask

  task automatic send(input logic [1:0] ch, input logic [PB-1:0] lvl);
    @(negedge clk);
    wait_ready("send");
    cmd_chan  = ch;
    cmd_level = lvl;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    wait_ready(name);
    while (busy != 3'b000 && n < 70*FRAME) begin @(negedge clk); n++; end
    check({name, " settle"}, int'(busy), 0);
  endtask

  task automatic measure(output int d0, output int d1, output int d2);
    d0 = 0; d1 = 0; d2 = 0;
    repeat (FRAME) begin
      @(negedge clk);
      d0 += int'(pwm[0]);
      d1 += int'(pwm[1]);
      d2 += int'(pwm[2]);
    end
  endtask

  initial begin
    int n, bad, ticks, d0, d1, d2, maxv, prev, jumps, c;
    tbl[0] = '{chan: 1, level: 16, exp_err: 0, exp0: 63, exp1: 16, exp2: 0};
    tbl[1] = '{chan: 3, level: 45, exp_err: 1, exp0: 63, exp1: 16, exp2: 0};
    tbl[2] = '{chan: 1, level: 5,  exp_err: 0, exp0: 63, exp1: 5,  exp2: 0};
    tbl[3] = '{chan: 2, level: 0,  exp_err: 0, exp0: 63, exp1: 5,  exp2: 0};
    tbl[4] = '{chan: 0, level: 0,  exp_err: 0, exp0: 0,  exp1: 5,  exp2: 0};

    // reset state and release
    repeat (3) @(negedge clk);
    check("reset outputs", int'({pwm, busy, frame_tick, cmd_ready, cmd_err}), 0);
    resetn = 1'b1;
    #1 check("ready before first edge", int'(cmd_ready), 0);
    @(negedge clk);
    check("ready after reset", int'(cmd_ready), 1);

    // idle frames
    wait_tick("idle");
    bad = 0;
    for (int f = 0; f < 3; f++) begin
      n = 0;
      do begin
        @(negedge clk); n++;
        if (pwm != 3'b000 || busy != 3'b000 || !cmd_ready) bad++;
      end while (!frame_tick && n < 2*FRAME);
      check("frame period", n, FRAME);
    end
    check("idle outputs", bad, 0);

    // full ramp of channel 0 to max
    send(2'd0, 6'd63);
    @(negedge clk);
    check("ch0 ready drop", int'(cmd_ready), 0);
    check("ch0 no err", int'(cmd_err), 0);
    wait_tick("ch0 apply");
    check("ready low on tick", int'(cmd_ready), 0);
    @(negedge clk);
    check("ready back", int'(cmd_ready), 1);
    check("busy ch0 set", int'(busy), 1);
    n = 0; ticks = 0;
    while (busy != 3'b000 && n < 70*FRAME) begin
      @(negedge clk); n++;
      if (frame_tick) ticks++;
    end
    check("ch0 step count", ticks, 63);
    check("ch0 cur max", int'(dut.cur[0]), 63);
    measure(d0, d1, d2);
    check("ch0 always on", d0, FRAME);

    // table of commands
    for (int k = 0; k < 5; k++) begin
      send(2'(tbl[k].chan), PB'(tbl[k].level));
      @(negedge clk);
      check($sformatf("v%0d err", k), int'(cmd_err), tbl[k].exp_err);
      check($sformatf("v%0d ready", k), int'(cmd_ready), tbl[k].exp_err);
      if (tbl[k].exp_err != 0) begin
        bad = 0;
        repeat (FRAME + 2) begin
          @(negedge clk);
          if (!cmd_ready || cmd_err) bad++;
        end
        check($sformatf("v%0d err single, ready kept", k), bad, 0);
      end
      wait_idle($sformatf("v%0d", k));
      check($sformatf("v%0d cur0", k), int'(dut.cur[0]), tbl[k].exp0);
      check($sformatf("v%0d cur1", k), int'(dut.cur[1]), tbl[k].exp1);
      check($sformatf("v%0d cur2", k), int'(dut.cur[2]), tbl[k].exp2);
      check($sformatf("v%0d tgt1", k), int'(dut.tgt[1]), tbl[k].exp1);
      measure(d0, d1, d2);
      check($sformatf("v%0d duty0", k), d0, tbl[k].exp0);
      check($sformatf("v%0d duty1", k), d1, tbl[k].exp1);
      check($sformatf("v%0d duty2", k), d2, tbl[k].exp2);
    end

    // command accepted on the tick cycle waits a full frame
    @(negedge clk);
    wait_tick("tick accept");
    check("ready on tick", int'(cmd_ready), 1);
    cmd_chan = 2'd1; cmd_level = 6'd8; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1) check("tgt1 held after tick accept", int'(dut.tgt[1]), 5);
    end while (!cmd_ready && n < 3*FRAME);
    check("tick accept latency", n, FRAME + 1);
    wait_idle("tick accept");
    check("ch1 at 8", int'(dut.cur[1]), 8);

    // redirect a ramp mid-flight
    send(2'd2, 6'd60);
    @(negedge clk);
    wait_ready("redirect");
    n = 0;
    while (dut.cur[2] != 6'd30 && n < 40*FRAME) begin @(negedge clk); n++; end
    check("ch2 reaches 30", int'(dut.cur[2]), 30);
    send(2'd2, 6'd10);
    maxv = 30; prev = 30; jumps = 0; n = 0;
    do begin
      @(negedge clk); n++;
      c = int'(dut.cur[2]);
      if (c > maxv) maxv = c;
      if (c > prev + 1 || c < prev - 1) jumps++;
      prev = c;
    end while (!(cmd_ready && busy == 3'b000) && n < 70*FRAME);
    check("redirect peak", maxv, 31);
    check("redirect jumps", jumps, 0);
    check("redirect final", prev, 10);

    // reset with a ramp active and a command pending
    send(2'd0, 6'd50);
    @(negedge clk);
    wait_ready("pre-reset");
    repeat (3) begin @(negedge clk); wait_tick("pre-reset ramp"); @(negedge clk); end
    check("ch0 ramping", int'(busy[0]), 1);
    send(2'd1, 6'd40);
    @(negedge clk);
    check("pending before reset", int'(cmd_ready), 0);
    resetn = 1'b0;
    #1 check("async reset outputs", int'({pwm, busy, frame_tick, cmd_ready, cmd_err}), 0);
    @(negedge clk);
    check("reset state", int'(dut.cur[0]) + int'(dut.tgt[0]) + int'(dut.tgt[1]), 0);
    check("held reset outputs", int'({pwm, busy, frame_tick, cmd_ready, cmd_err}), 0);
    resetn = 1'b1;
    @(negedge clk);
    check("ready after re-release", int'(cmd_ready), 1);
    bad = 0;
    repeat (2*FRAME + 4) begin
      @(negedge clk);
      if (dut.tgt[0] != 0 || dut.tgt[1] != 0 || dut.tgt[2] != 0 ||
          busy != 3'b000 || pwm != 3'b000 || !cmd_ready) bad++;
    end
    check("no stale command", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
